// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - per-register latency scoreboard driving ID-stage RAW/WAW stall
// Optional perf counters: define HAZARD_PERF_CNT_EN.
module hazard_scoreboard #(
    parameter int NREG  = 32,
    parameter int AW    = 5,
    parameter int LAT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             hold,
    input  logic             id_valid,
    input  logic [AW-1:0]    id_rs,
    input  logic [AW-1:0]    id_rt,
    input  logic             id_rs_used,
    input  logic             id_rt_used,
    input  logic             id_early,
    input  logic             id_wr_en,
    input  logic [AW-1:0]    id_wr_addr,
    input  logic [LAT_W-1:0] id_wr_lat,
`ifdef HAZARD_PERF_CNT_EN
    output logic [31:0]      perf_raw_cycles,
    output logic [31:0]      perf_waw_cycles,
`endif
    output logic             stall,
    output logic             stall_raw,
    output logic             stall_waw,
    output logic [NREG-1:0]  busy_vec
);

    // Register 0 has no storage; addresses >= NREG never match any slot.
    logic [LAT_W-1:0] cnt [1:NREG-1];

    logic [LAT_W-1:0] cnt_rs;
    logic [LAT_W-1:0] cnt_rt;
    logic [LAT_W-1:0] cnt_wr;
    logic [LAT_W-1:0] thr;
    logic             raw_a;
    logic             raw_b;
    logic             issue;

    always_comb begin
        cnt_rs = '0;
        cnt_rt = '0;
        cnt_wr = '0;
        for (int r = 1; r < NREG; r++) begin
            if (id_rs == AW'(r))      cnt_rs = cnt[r];
            if (id_rt == AW'(r))      cnt_rt = cnt[r];
            if (id_wr_addr == AW'(r)) cnt_wr = cnt[r];
        end
    end

    // EX consumers are served by the bypass one cycle later, hence the looser threshold.
    assign thr       = id_early ? LAT_W'(0) : LAT_W'(1);
    assign raw_a     = id_rs_used && (cnt_rs > thr);
    assign raw_b     = id_rt_used && (cnt_rt > thr);
    assign stall_raw = id_valid && (raw_a || raw_b);
    assign stall_waw = id_valid && id_wr_en && (cnt_wr > id_wr_lat);
    assign stall     = stall_raw || stall_waw;

    assign issue = id_valid && !stall && !hold && id_wr_en &&
                   (id_wr_addr != '0) && (id_wr_lat != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 1; r < NREG; r++) cnt[r] <= '0;
        end else if (!hold) begin
            for (int r = 1; r < NREG; r++) begin
                if (issue && (id_wr_addr == AW'(r))) cnt[r] <= id_wr_lat;
                else if (cnt[r] != '0)               cnt[r] <= cnt[r] - LAT_W'(1);
            end
        end
    end

    always_comb begin
        busy_vec    = '0;
        for (int r = 1; r < NREG; r++) busy_vec[r] = (cnt[r] != '0);
    end

`ifdef HAZARD_PERF_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_raw_cycles <= '0;
            perf_waw_cycles <= '0;
        end else if (!hold) begin
            if (stall_raw) perf_raw_cycles <= perf_raw_cycles + 32'd1;
            if (stall_waw) perf_waw_cycles <= perf_waw_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb/tb_hazard_scoreboard.sv - directed self-checking bench for hazard_scoreboard
module tb_hazard_scoreboard;
    localparam int NREG = 32, AW = 5, LAT_W = 3;

    logic             clk = 1'b0;
    logic             rst;
    logic             hold;
    logic             id_valid;
    logic [AW-1:0]    id_rs, id_rt, id_wr_addr;
    logic             id_rs_used, id_rt_used, id_early, id_wr_en;
    logic [LAT_W-1:0] id_wr_lat;
    logic             stall, stall_raw, stall_waw;
    logic [NREG-1:0]  busy_vec;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0]      perf_raw_cycles, perf_waw_cycles;
`endif

    int errors = 0;
    int checks = 0;
    int nstall;

    always #5 clk = ~clk;

    hazard_scoreboard #(.NREG(NREG), .AW(AW), .LAT_W(LAT_W)) dut (
        .clk(clk), .rst(rst), .hold(hold), .id_valid(id_valid),
        .id_rs(id_rs), .id_rt(id_rt), .id_rs_used(id_rs_used), .id_rt_used(id_rt_used),
        .id_early(id_early), .id_wr_en(id_wr_en), .id_wr_addr(id_wr_addr),
        .id_wr_lat(id_wr_lat),
`ifdef HAZARD_PERF_CNT_EN
        .perf_raw_cycles(perf_raw_cycles), .perf_waw_cycles(perf_waw_cycles),
`endif
        .stall(stall), .stall_raw(stall_raw), .stall_waw(stall_waw), .busy_vec(busy_vec)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic idle();
        id_valid = 0; id_rs = 0; id_rt = 0; id_rs_used = 0; id_rt_used = 0;
        id_early = 0; id_wr_en = 0; id_wr_addr = 0; id_wr_lat = 0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [LAT_W-1:0] lat);
        idle();
        id_valid = 1; id_wr_en = 1; id_wr_addr = a; id_wr_lat = lat;
        #1;
    endtask

    task automatic rd(input logic [AW-1:0] a, input logic use_rt, input logic early);
        idle();
        id_valid = 1; id_early = early;
        if (use_rt) begin id_rt = a; id_rt_used = 1; end
        else        begin id_rs = a; id_rs_used = 1; end
        #1;
    endtask

    initial begin
        rst = 1; hold = 0; idle();
        #1;
        check("reset_busy", 32'(busy_vec), 0);
        check("reset_stall", 32'(stall), 0);
        step(); step();
        rst = 0;
        #1;

        // 1: ALU result, EX consumer bypassed, ID consumer stalls one cycle
        wr(3, 1);
        check("t1_issue_nostall", 32'(stall), 0);
        step();
        rd(3, 0, 0);
        check("t1_busy3", 32'(busy_vec[3]), 1);
        check("t1_ex_bypass", 32'(stall), 0);
        step();
        wr(3, 1); step();
        rd(3, 0, 1);
        check("t1_early_stall", 32'(stall), 1);
        check("t1_early_raw", 32'(stall_raw), 1);
        step(); #1;
        check("t1_early_clear", 32'(stall), 0);
        step();

        // 2: load-use
        wr(5, 2); step();
        rd(5, 1, 0);
        check("t2_loaduse_stall", 32'(stall), 1);
        step(); #1;
        check("t2_loaduse_clear", 32'(stall), 0);
        check("t2_busy5_mid", 32'(busy_vec[5]), 1);
        step(); #1;
        check("t2_busy5_done", 32'(busy_vec[5]), 0);

        // 3: long write followed by short write to the same register
        wr(8, 7); step();
        wr(8, 1);
        check("t3_waw_first", 32'(stall_waw), 1);
        check("t3_waw_noraw", 32'(stall_raw), 0);
        nstall = 0;
        for (int i = 0; i < 20 && stall; i++) begin
            nstall++;
            step(); #1;
        end
        check("t3_waw_cycles", 32'(nstall), 6);
        step();
        idle(); #1;
        check("t3_reload", 32'(busy_vec[8]), 1);
        step(); #1;
        check("t3_drain", 32'(busy_vec[8]), 0);

        // 4: register zero
        wr(0, 5);
        check("t4_wr0_stall", 32'(stall), 0);
        step();
        rd(0, 0, 1);
        check("t4_busy0", 32'(busy_vec), 0);
        check("t4_rd0_stall", 32'(stall), 0);
        step();

        // 5: hold freezes the counters
        wr(4, 3); step();
        hold = 1;
        rd(4, 0, 0);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("t5_hold_stall%0d", i), 32'(stall), 1);
            step(); #1;
        end
        hold = 0; #1;
        check("t5_cnt3", 32'(stall), 1);
        step(); #1;
        check("t5_cnt2", 32'(stall), 1);
        step(); #1;
        check("t5_cnt1_ex", 32'(stall), 0);
        id_early = 1; #1;
        check("t5_cnt1_early", 32'(stall), 1);
        step(); #1;
        check("t5_cnt0", 32'(busy_vec[4]), 0);

        // 6: asynchronous reset mid-flight
        wr(10, 7); step();
        wr(11, 7); step();
        rd(10, 0, 1);
        check("t6_busy_pre", 32'(busy_vec), 32'h0000_0C00);
        check("t6_stall_pre", 32'(stall), 1);
`ifdef HAZARD_PERF_CNT_EN
        check("t6_perf_raw_pre", 32'(perf_raw_cycles != 0), 1);
        check("t6_perf_waw_pre", 32'(perf_waw_cycles != 0), 1);
`endif
        #1 rst = 1;
        #1;
        check("t6_busy_rst", 32'(busy_vec), 0);
        check("t6_stall_rst", 32'(stall), 0);
`ifdef HAZARD_PERF_CNT_EN
        check("t6_perf_raw_rst", perf_raw_cycles, 0);
        check("t6_perf_waw_rst", perf_waw_cycles, 0);
`endif
        #1 rst = 0;
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end
endmodule
